// File: rtl/super_pkg.sv
// super_pkg: shared front-end types.
//   ir_reg_t    : one predicted instruction as carried from the branch
//                 predictor to decode (pc, raw instruction, prediction).
//   NULL_IR_REG : all-zero idle value for an ir_reg_t.
package super_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ptaken;
    logic [31:0] ptarget;
  } ir_reg_t;

  localparam ir_reg_t NULL_IR_REG = '0;

endpackage

// File: rtl/ir_queue_if.sv
// ir_queue_if: bundle of the instruction-queue handshake signals.
//   master : predictor/decode side (drives flush, input pair, decode ready)
//   slave  : queue side (drives ready to predictor, output pair)
interface ir_queue_if;
  import super_pkg::*;

  logic       flush;
  logic [1:0] in_valid;
  ir_reg_t    in_instr0;
  ir_reg_t    in_instr1;
  logic [1:0] ds_rdy;
  logic [1:0] out_valid;
  ir_reg_t    out_instr0;
  ir_reg_t    out_instr1;
  logic [1:0] de_rdy;

  modport master (
    output flush, in_valid, in_instr0, in_instr1, de_rdy,
    input  ds_rdy, out_valid, out_instr0, out_instr1
  );

  modport slave (
    input  flush, in_valid, in_instr0, in_instr1, de_rdy,
    output ds_rdy, out_valid, out_instr0, out_instr1
  );
endinterface

// File: rtl/ir_queue.sv
// ir_queue: two-wide in-order instruction queue between the branch
// predictor and decode.
//   clk_i, rst_ni        : clock, async active-low reset
//   flush_i              : drop every queued instruction (redirect)
//   in_valid_i[1:0]      : input pair valid (in order, slot 0 oldest)
//   in_instr0_i/1_i      : predicted instructions
//   ds_rdy_o[1:0]        : room for one / two more entries
//   out_valid_o[1:0]     : output pair valid
//   out_instr0_o/1_o     : oldest two entries (NULL_IR_REG when invalid)
//   de_rdy_i[1:0]        : decode accepts slot 0 / slot 1
// Build option: define IR_QUEUE_BYPASS_EN to let an empty queue forward
// accepted inputs straight to the outputs in the same cycle.
module ir_queue
  import super_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic [1:0] in_valid_i,
  input  ir_reg_t    in_instr0_i,
  input  ir_reg_t    in_instr1_i,
  output logic [1:0] ds_rdy_o,
  output logic [1:0] out_valid_o,
  output ir_reg_t    out_instr0_o,
  output ir_reg_t    out_instr1_o,
  input  logic [1:0] de_rdy_i
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  ir_reg_t       mem_q [Depth];

  logic [1:0] in_v, de_v;
  logic       push0, push1, pop0, pop1;
  logic [1:0] n_push, n_pop, wr_adv, rd_adv;
  logic       we0, we1;
  ir_reg_t    wd0, wd1;

  // 2'b10 is not a legal in-order pattern; treat it as nothing offered.
  assign in_v = (in_valid_i == 2'b10) ? 2'b00 : in_valid_i;
  assign de_v = (de_rdy_i == 2'b10) ? 2'b00 : de_rdy_i;

  assign ds_rdy_o[0] = (count_q <= CW'(Depth - 1));
  assign ds_rdy_o[1] = (count_q <= CW'(Depth - 2));

  assign push0 = in_v[0] & ds_rdy_o[0];
  assign push1 = push0 & in_v[1] & ds_rdy_o[1];

  always_comb begin
    out_valid_o  = {(count_q > CW'(1)), (count_q != '0)};
    out_instr0_o = out_valid_o[0] ? mem_q[rd_ptr_q] : NULL_IR_REG;
    out_instr1_o = out_valid_o[1] ? mem_q[rd_ptr_q + AW'(1)] : NULL_IR_REG;
`ifdef IR_QUEUE_BYPASS_EN
    if (count_q == '0 && !flush_i) begin
      out_valid_o  = {push1, push0};
      out_instr0_o = push0 ? in_instr0_i : NULL_IR_REG;
      out_instr1_o = push1 ? in_instr1_i : NULL_IR_REG;
    end
`endif
  end

  assign pop0 = out_valid_o[0] & de_v[0];
  assign pop1 = pop0 & out_valid_o[1] & de_v[1];

  assign n_push  = {1'b0, push0} + {1'b0, push1};
  assign n_pop   = {1'b0, pop0} + {1'b0, pop1};
  assign count_d = count_q + CW'(n_push) - CW'(n_pop);

  always_comb begin
    we0    = push0;
    we1    = push1;
    wd0    = in_instr0_i;
    wd1    = in_instr1_i;
    wr_adv = n_push;
    rd_adv = n_pop;
`ifdef IR_QUEUE_BYPASS_EN
    // Bypassed entries consumed this cycle never touch storage; any
    // leftover input is written at wr_ptr so order is kept.
    if (count_q == '0 && !flush_i) begin
      rd_adv = 2'd0;
      wr_adv = n_push - n_pop;
      if (pop1) begin
        we0 = 1'b0;
        we1 = 1'b0;
      end else if (pop0) begin
        we0 = push1;
        wd0 = in_instr1_i;
        we1 = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= NULL_IR_REG;
    end else if (flush_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (we0) mem_q[wr_ptr_q] <= wd0;
      if (we1) mem_q[wr_ptr_q + AW'(1)] <= wd1;
      wr_ptr_q <= wr_ptr_q + AW'(wr_adv);
      rd_ptr_q <= rd_ptr_q + AW'(rd_adv);
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_ir_queue.sv
module tb_ir_queue;
  import super_pkg::*;

  localparam int Depth = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ir_queue_if qif ();

  ir_queue #(.Depth(Depth)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (qif.flush),
    .in_valid_i  (qif.in_valid),
    .in_instr0_i (qif.in_instr0),
    .in_instr1_i (qif.in_instr1),
    .ds_rdy_o    (qif.ds_rdy),
    .out_valid_o (qif.out_valid),
    .out_instr0_o(qif.out_instr0),
    .out_instr1_o(qif.out_instr1),
    .de_rdy_i    (qif.de_rdy)
  );

  int n_cmp = 0;
  int n_fail = 0;
  ir_reg_t q[$];

`ifdef IR_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic ir_reg_t mk(input logic [31:0] pc);
    ir_reg_t r;
    r.pc      = pc;
    r.instr   = $urandom;
    r.ptaken  = 1'($urandom_range(0, 1));
    r.ptarget = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle, compare DUT against the queue model,
  // then advance the model to what the next edge must produce.
  task automatic drive(input logic fl, input logic [1:0] inv, input ir_reg_t i0,
                       input ir_reg_t i1, input logic [1:0] der);
    int sz, npop;
    logic [1:0] iv, dv, ds_e, ov_e;
    logic p0, p1, q0, q1;
    ir_reg_t o0_e, o1_e;
    @(negedge clk);
    qif.flush = fl; qif.in_valid = inv; qif.in_instr0 = i0;
    qif.in_instr1 = i1; qif.de_rdy = der;
    #1;
    sz = q.size();
    iv = (inv == 2'b10) ? 2'b00 : inv;
    dv = (der == 2'b10) ? 2'b00 : der;
    ds_e = {(Depth - sz >= 2), (Depth - sz >= 1)};
    p0 = iv[0] & ds_e[0];
    p1 = p0 & iv[1] & ds_e[1];
    if (BYP && sz == 0 && !fl) begin
      ov_e = {p1, p0};
      o0_e = p0 ? i0 : NULL_IR_REG;
      o1_e = p1 ? i1 : NULL_IR_REG;
    end else begin
      ov_e = {(sz >= 2), (sz >= 1)};
      o0_e = (sz >= 1) ? q[0] : NULL_IR_REG;
      o1_e = (sz >= 2) ? q[1] : NULL_IR_REG;
    end
    chk("ds_rdy", 128'(qif.ds_rdy), 128'(ds_e));
    chk("out_valid", 128'(qif.out_valid), 128'(ov_e));
    chk("out_instr0", 128'(qif.out_instr0), 128'(o0_e));
    chk("out_instr1", 128'(qif.out_instr1), 128'(o1_e));
    q0 = ov_e[0] & dv[0];
    q1 = q0 & ov_e[1] & dv[1];
    npop = int'(q0) + int'(q1);
    if (fl) q.delete();
    else begin
      if (p0) q.push_back(i0);
      if (p1) q.push_back(i1);
      repeat (npop) void'(q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    qif.flush = 1'b0; qif.in_valid = 2'b00; qif.de_rdy = 2'b00;
    #1;
  endtask

  task automatic cyc(input logic fl, input logic [1:0] inv, input ir_reg_t i0,
                     input ir_reg_t i1, input logic [1:0] der);
    drive(fl, inv, i0, i1, der);
    tick();
  endtask

  logic [31:0] pc;

  initial begin
    qif.flush = 1'b0; qif.in_valid = 2'b00; qif.de_rdy = 2'b00;
    qif.in_instr0 = NULL_IR_REG; qif.in_instr1 = NULL_IR_REG;
    #12;
    chk("rst_out_valid", 128'(qif.out_valid), 128'(2'b00));
    chk("rst_ds_rdy", 128'(qif.ds_rdy), 128'(2'b11));
    chk("rst_out_instr0", 128'(qif.out_instr0), 128'(NULL_IR_REG));
    rst_n = 1'b1;

    // Fill
    cyc(0, 2'b11, mk(32'h100), mk(32'h104), 2'b00);
    chk("fill1_valid", 128'(qif.out_valid), 128'(2'b11));
    chk("fill1_rdy", 128'(qif.ds_rdy), 128'(2'b11));
    chk("fill1_pc0", 128'(qif.out_instr0.pc), 128'(32'h100));
    chk("fill1_pc1", 128'(qif.out_instr1.pc), 128'(32'h104));
    cyc(0, 2'b11, mk(32'h108), mk(32'h10c), 2'b00);
    chk("fill2_rdy", 128'(qif.ds_rdy), 128'(2'b00));
    cyc(0, 2'b11, mk(32'h110), mk(32'h114), 2'b00);
    chk("fill3_rdy", 128'(qif.ds_rdy), 128'(2'b00));
    chk("fill3_pc0", 128'(qif.out_instr0.pc), 128'(32'h100));

    // Full with simultaneous push/pop: no push, count 4 -> 2
    drive(0, 2'b11, mk(32'h110), mk(32'h114), 2'b11);
    chk("full_pp_rdy_same", 128'(qif.ds_rdy), 128'(2'b00));
    tick();
    chk("full_pp_valid", 128'(qif.out_valid), 128'(2'b11));
    chk("full_pp_rdy", 128'(qif.ds_rdy), 128'(2'b11));
    chk("full_pp_pc0", 128'(qif.out_instr0.pc), 128'(32'h108));

    // Partial accept at count 3
    cyc(0, 2'b01, mk(32'h118), mk(32'h0), 2'b00);
    chk("cnt3_rdy", 128'(qif.ds_rdy), 128'(2'b01));
    cyc(0, 2'b11, mk(32'h11c), mk(32'h120), 2'b00);
    chk("partial_rdy", 128'(qif.ds_rdy), 128'(2'b00));
    chk("partial_valid", 128'(qif.out_valid), 128'(2'b11));

    // Flush at count 3 overrides push and pop
    cyc(0, 2'b00, mk(32'h0), mk(32'h0), 2'b01);
    cyc(1, 2'b11, mk(32'h124), mk(32'h128), 2'b11);
    chk("flush_valid", 128'(qif.out_valid), 128'(2'b00));
    chk("flush_rdy", 128'(qif.ds_rdy), 128'(2'b11));

    // One-in/one-out across pointer wrap
    cyc(0, 2'b01, mk(32'h100), mk(32'h0), 2'b00);
    for (int k = 1; k <= 10; k++) begin
      drive(0, 2'b01, mk(32'h100 + 32'(4 * k)), mk(32'h0), 2'b01);
      chk("wrap_pc0", 128'(qif.out_instr0.pc), 128'(32'h100 + 32'(4 * (k - 1))));
      chk("wrap_valid", 128'(qif.out_valid), 128'(2'b01));
      tick();
    end
    cyc(0, 2'b00, mk(32'h0), mk(32'h0), 2'b01);
    chk("wrap_empty", 128'(qif.out_valid), 128'(2'b00));

    // Empty queue, pair in, decode takes one
    drive(0, 2'b11, mk(32'h200), mk(32'h204), 2'b01);
    chk("byp_same_valid", 128'(qif.out_valid), BYP ? 128'(2'b11) : 128'(2'b00));
    tick();
    chk("byp_next_valid", 128'(qif.out_valid), BYP ? 128'(2'b01) : 128'(2'b11));
    chk("byp_next_pc0", 128'(qif.out_instr0.pc), BYP ? 128'(32'h204) : 128'(32'h200));
    cyc(1, 2'b00, mk(32'h0), mk(32'h0), 2'b00);

    // Randomized traffic against the model, with one async reset
    pc = 32'h1000;
    for (int n = 0; n < 500; n++) begin
      logic [1:0] inv, der;
      logic fl;
      ir_reg_t a, b;
      inv = 2'($urandom_range(0, 3));
      der = 2'($urandom_range(0, 3));
      fl  = ($urandom_range(0, 29) == 0);
      a = mk(pc); b = mk(pc + 32'h4);
      pc = pc + 32'h8;
      cyc(fl, inv, a, b, der);
      if (n == 250) begin
        if (q.size() == 0) cyc(0, 2'b11, mk(32'h3000), mk(32'h3004), 2'b00);
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("async_rst_valid", 128'(qif.out_valid), 128'(2'b00));
        chk("async_rst_rdy", 128'(qif.ds_rdy), 128'(2'b11));
        chk("async_rst_instr0", 128'(qif.out_instr0), 128'(NULL_IR_REG));
        #1;
        rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
